// File: rtl/sysbus_arbiter_if.sv
// Sysbus request/response channel bundle.
// master drives requests and the response ack; slave drives acks and responses.
interface sysbus_arbiter_if #(
    parameter int TAG_WIDTH = 13
) ();
    logic                 reqcyc;
    logic [63:0]          req;
    logic [TAG_WIDTH-1:0] reqtag;
    logic                 reqack;
    logic                 respcyc;
    logic [63:0]          resp;
    logic [TAG_WIDTH-1:0] resptag;
    logic                 respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Two-master round-robin arbiter for the Sysbus channel (m0 = fetch, m1 = data).
// Grant is held for a whole transaction: address beat, then either BEATS write
// data beats or BEATS read response beats. Responses go only to the owner.
module sysbus_arbiter #(
    parameter int TAG_WIDTH = 13,
    parameter int BEATS     = 8
) (
    input  logic              clk,
    input  logic              reset,
    sysbus_arbiter_if.slave   m0,
    sysbus_arbiter_if.slave   m1,
    sysbus_arbiter_if.master  bus,
    output logic              busy,
    output logic              owner,
    output logic              err
);
    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {IDLE, ADDR, WDATA, RESP} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt, cnt_inc;
    logic                 ptr, ptr_nxt;
    logic                 owner_nxt;
    logic                 err_nxt;
    logic                 fwd;     // forward owner's request lines to the bus
    logic                 ack;     // owner beat accepted this cycle
    logic                 rsp;     // response beat routed to owner this cycle

    logic                 own_cyc;
    logic [63:0]          own_req;
    logic [TAG_WIDTH-1:0] own_tag;

    assign own_cyc = owner ? m1.reqcyc : m0.reqcyc;
    assign own_req = owner ? m1.req    : m0.req;
    assign own_tag = owner ? m1.reqtag : m0.reqtag;
    assign cnt_inc = cnt + CW'(1);

    // State, beat counter, priority pointer, owner and sticky error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
            owner <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            err   <= err_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        fwd       = 1'b0;
        ack       = 1'b0;
        rsp       = 1'b0;
        // A response outside the response phase belongs to nobody: flag it, never ack it.
        err_nxt   = err | (bus.respcyc & (state != RESP));
        case (state)
            IDLE: begin
                if (m0.reqcyc || m1.reqcyc) begin
                    // Lone requester wins; a tie goes to the pointer.
                    owner_nxt = (m0.reqcyc && m1.reqcyc) ? ptr : m1.reqcyc;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                fwd = 1'b1;
                if (!own_cyc) begin
                    // Abandoned before the address was taken; pointer keeps its value.
                    state_nxt = IDLE;
                end else if (bus.reqack) begin
                    ack       = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = own_tag[TAG_WIDTH-1] ? RESP : WDATA;
                end
            end
            WDATA: begin
                fwd = 1'b1;
                if (own_cyc && bus.reqack) begin
                    ack     = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CW'(BEATS)) begin
                        state_nxt = IDLE;
                        ptr_nxt   = ~owner;
                    end
                end
            end
            RESP: begin
                if (bus.respcyc) begin
                    rsp     = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CW'(BEATS)) begin
                        state_nxt = IDLE;
                        ptr_nxt   = ~owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    assign bus.reqcyc  = fwd & own_cyc;
    assign bus.req     = fwd ? own_req : '0;
    assign bus.reqtag  = fwd ? own_tag : '0;
    assign bus.respack = rsp;

    assign m0.reqack  = ack & ~owner;
    assign m1.reqack  = ack &  owner;
    assign m0.respcyc = rsp & ~owner;
    assign m1.respcyc = rsp &  owner;
    assign m0.resp    = (state == RESP && !owner) ? bus.resp    : '0;
    assign m1.resp    = (state == RESP &&  owner) ? bus.resp    : '0;
    assign m0.resptag = (state == RESP && !owner) ? bus.resptag : '0;
    assign m1.resptag = (state == RESP &&  owner) ? bus.resptag : '0;
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reads, writes with stalls, round-robin,
// abandoned address, spurious response and asynchronous reset mid-read.
module tb_sysbus_arbiter;
    localparam int TW = 13;
    localparam logic [TW-1:0] RD = 13'h1000;
    localparam logic [TW-1:0] WR = 13'h0005;

    logic clk = 1'b0;
    logic reset;
    logic busy, owner, err;
    int   n_pass = 0;
    int   n_tot  = 0;

    sysbus_arbiter_if #(.TAG_WIDTH(TW)) m0_if ();
    sysbus_arbiter_if #(.TAG_WIDTH(TW)) m1_if ();
    sysbus_arbiter_if #(.TAG_WIDTH(TW)) bus_if ();

    sysbus_arbiter #(.TAG_WIDTH(TW), .BEATS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .m0    (m0_if),
        .m1    (m1_if),
        .bus   (bus_if),
        .busy  (busy),
        .owner (owner),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
            $error("%s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Eight response beats routed to master `who`, then check return to IDLE.
    task automatic resp_beats(input logic who, input logic [63:0] base);
        for (int i = 0; i < 8; i++) begin
            bus_if.respcyc = 1'b1;
            bus_if.resp    = base + 64'(i);
            bus_if.resptag = RD | TW'(i);
            #1;
            chk("own_respcyc", who ? m1_if.respcyc : m0_if.respcyc, 1);
            chk("own_resp",    who ? m1_if.resp    : m0_if.resp,    base + 64'(i));
            chk("oth_respcyc", who ? m0_if.respcyc : m1_if.respcyc, 0);
            chk("bus_respack", bus_if.respack, 1);
            if (i == 3) chk("own_resptag", who ? m1_if.resptag : m0_if.resptag, RD | TW'(3));
            tick();
        end
        bus_if.respcyc = 1'b0;
        bus_if.resp    = '0;
        bus_if.resptag = '0;
        #1;
        chk("busy_after_resp", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        m0_if.reqcyc = 0; m0_if.req = '0; m0_if.reqtag = '0; m0_if.respack = 0;
        m1_if.reqcyc = 0; m1_if.req = '0; m1_if.reqtag = '0; m1_if.respack = 0;
        bus_if.reqack = 0; bus_if.respcyc = 0; bus_if.resp = '0; bus_if.resptag = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_err", err, 0);
        chk("rst_bus_reqcyc", bus_if.reqcyc, 0);
        tick(); tick();
        reset = 1'b0;

        // Simultaneous read requests: pointer starts at m0.
        m0_if.reqcyc = 1; m0_if.req = 64'h100; m0_if.reqtag = RD;
        m1_if.reqcyc = 1; m1_if.req = 64'h200; m1_if.reqtag = RD;
        #1;
        chk("idle_latency", bus_if.reqcyc, 0);
        tick();
        chk("rr1_owner", owner, 0);
        chk("rr1_bus_req", bus_if.req, 64'h100);
        bus_if.reqack = 1; #1;
        chk("rr1_m0_ack", m0_if.reqack, 1);
        chk("rr1_m1_ack", m1_if.reqack, 0);
        tick();
        bus_if.reqack = 0; m0_if.reqcyc = 0;
        resp_beats(0, 64'hB0);

        // m1 still requesting: granted on this IDLE.
        tick();
        chk("rr2_owner", owner, 1);
        chk("rr2_bus_req", bus_if.req, 64'h200);
        m0_if.reqcyc = 1;
        bus_if.reqack = 1; #1;
        chk("rr2_m1_ack", m1_if.reqack, 1);
        chk("rr2_m0_ack", m0_if.reqack, 0);
        tick();
        bus_if.reqack = 0; m1_if.reqcyc = 0;
        resp_beats(1, 64'hC0);

        // Both request again: round-robin returns to m0.
        m1_if.reqcyc = 1; m1_if.req = 64'h2000; m1_if.reqtag = WR;
        tick();
        chk("rr3_owner", owner, 0);

        // m0 abandons its address beat; m1 is granted next.
        m0_if.reqcyc = 0; #1;
        chk("drop_bus_reqcyc", bus_if.reqcyc, 0);
        tick();
        chk("drop_busy", busy, 0);
        tick();
        chk("drop_m1_owner", owner, 1);
        chk("wr_addr", bus_if.req, 64'h2000);

        // m1 write: address then 8 data beats, bus stalls every other cycle.
        bus_if.reqack = 1; #1;
        chk("wr_addr_ack", m1_if.reqack, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            m1_if.req = 64'hD0 + 64'(i);
            bus_if.reqack = 0; #1;
            chk("wr_stall_ack", m1_if.reqack, 0);
            chk("wr_stall_busy", busy, 1);
            tick();
            bus_if.reqack = 1; #1;
            chk("wr_data", bus_if.req, 64'hD0 + 64'(i));
            chk("wr_data_ack", m1_if.reqack, 1);
            chk("wr_no_resp", m1_if.respcyc, 0);
            tick();
        end
        bus_if.reqack = 0; m1_if.reqcyc = 0; #1;
        chk("wr_done_busy", busy, 0);

        // Pointer is back at m0 after the write.
        m0_if.reqcyc = 1; m1_if.reqcyc = 1;
        tick();
        chk("ptr_m0_after_wr", owner, 0);
        m0_if.reqcyc = 0; m1_if.reqcyc = 0;
        tick();

        // m0 read alone, bus acks after two cycles, beats 0xA0..0xA7.
        m0_if.reqcyc = 1; m0_if.req = 64'h1000; m0_if.reqtag = RD;
        tick();
        chk("rd_bus_reqcyc", bus_if.reqcyc, 1);
        chk("rd_bus_req", bus_if.req, 64'h1000);
        chk("rd_wait_ack", m0_if.reqack, 0);
        tick(); tick();
        bus_if.reqack = 1; #1;
        chk("rd_ack", m0_if.reqack, 1);
        chk("rd_bus_tag", bus_if.reqtag, RD);
        tick();
        bus_if.reqack = 0; m0_if.reqcyc = 0;
        resp_beats(0, 64'hA0);

        // Spurious response in IDLE.
        bus_if.respcyc = 1; #1;
        chk("spur_respack", bus_if.respack, 0);
        chk("spur_m0_resp", m0_if.respcyc, 0);
        chk("spur_m1_resp", m1_if.respcyc, 0);
        tick();
        bus_if.respcyc = 0;
        chk("spur_err", err, 1);
        tick();
        chk("spur_err_sticky", err, 1);

        // m1 read, reset during the 4th response beat.
        m1_if.reqcyc = 1; m1_if.req = 64'h3000; m1_if.reqtag = RD;
        tick();
        bus_if.reqack = 1;
        tick();
        bus_if.reqack = 0; m1_if.reqcyc = 0;
        for (int i = 0; i < 3; i++) begin
            bus_if.respcyc = 1; bus_if.resp = 64'hE0 + 64'(i);
            tick();
        end
        bus_if.resp = 64'hE3; #1;
        chk("pre_rst_respcyc", m1_if.respcyc, 1);
        reset = 1'b1; #1;
        chk("arst_respcyc", m1_if.respcyc, 0);
        chk("arst_resp", m1_if.resp, 0);
        chk("arst_respack", bus_if.respack, 0);
        chk("arst_busy", busy, 0);
        chk("arst_owner", owner, 0);
        chk("arst_err", err, 0);
        bus_if.respcyc = 0; bus_if.resp = '0;
        tick();
        reset = 1'b0;

        // Fresh m1 read completes normally.
        m1_if.reqcyc = 1;
        tick();
        chk("post_owner", owner, 1);
        bus_if.reqack = 1; #1;
        chk("post_ack", m1_if.reqack, 1);
        tick();
        bus_if.reqack = 0; m1_if.reqcyc = 0;
        resp_beats(1, 64'hF0);
        chk("post_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
